// File: rtl/preset_timer.sv
// Phase countdown timer: loads a preset in seconds, decrements once per prescaled
// second, and pulses tick/expired; tens/ones give the BCD digits of the remaining count.
module preset_timer #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] preset,
  input  logic             pause,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       tens,
  output logic [3:0]       ones,
  output logic             running,
  output logic             tick,
  output logic             expired
);

  // With CLK_DIV==1 the prescaler is a 1-bit register that never leaves 0.
  localparam int unsigned PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_TOP = PW'(CLK_DIV - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          sec_done;

  assign sec_done = (prescaler == PS_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      running   <= 1'b0;
      tick      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      tick    <= 1'b0;
      expired <= 1'b0;
      if (load) begin
        // A load wins over both the pending tick and pause.
        prescaler <= '0;
        remaining <= preset;
        if (preset != '0) begin
          state   <= RUN;
          running <= 1'b1;
        end else begin
          state   <= IDLE;
          running <= 1'b0;
          expired <= 1'b1;
        end
      end else if (state == RUN && !pause) begin
        if (sec_done) begin
          prescaler <= '0;
          remaining <= remaining - CNT_W'(1);
          tick      <= 1'b1;
          if (remaining == CNT_W'(1)) begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  always_comb begin
    tens = 3'(remaining / CNT_W'(10));
    ones = 4'(remaining % CNT_W'(10));
  end

endmodule

// File: tb/tb_preset_timer.sv
// Bench for preset_timer: a CLK_DIV=4 and a CLK_DIV=1 instance share stimulus and are
// compared every cycle against a seconds-level countdown model, plus literal checkpoints.
module tb_preset_timer;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DIV_B = 1;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [5:0] preset;
  logic       pause;

  logic [5:0] rem_a, rem_b;
  logic [2:0] tens_a, tens_b;
  logic [3:0] ones_a, ones_b;
  logic       run_a, run_b, tick_a, tick_b, exp_a, exp_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  preset_timer #(.CLK_DIV(DIV_A), .CNT_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .pause(pause),
    .remaining(rem_a), .tens(tens_a), .ones(ones_a),
    .running(run_a), .tick(tick_a), .expired(exp_a)
  );

  preset_timer #(.CLK_DIV(DIV_B), .CNT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .pause(pause),
    .remaining(rem_b), .tens(tens_b), .ones(ones_b),
    .running(run_b), .tick(tick_b), .expired(exp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: seconds left plus unpaused cycles elapsed in the current second.
  typedef struct {
    int unsigned rem;
    int unsigned cyc;
    bit          tick;
    bit          exp;
  } model_t;

  model_t m_a = '{default: 0};
  model_t m_b = '{default: 0};

  function automatic model_t advance(input model_t s, input int unsigned div,
                                     input logic ld, input logic [5:0] p, input logic ps);
    model_t n;
    n      = s;
    n.tick = 1'b0;
    n.exp  = 1'b0;
    if (ld) begin
      n.rem = p;
      n.cyc = 0;
      n.exp = (p == 0);
    end else if (s.rem != 0 && !ps) begin
      n.cyc = s.cyc + 1;
      if (n.cyc == div) begin
        n.cyc  = 0;
        n.rem  = s.rem - 1;
        n.tick = 1'b1;
        n.exp  = (n.rem == 0);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '{default: 0};
      m_b <= '{default: 0};
    end else begin
      m_a <= advance(m_a, DIV_A, load, preset, pause);
      m_b <= advance(m_b, DIV_B, load, preset, pause);
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rem_a",  rem_a,  m_a.rem);
    chk("tens_a", tens_a, m_a.rem / 10);
    chk("ones_a", ones_a, m_a.rem % 10);
    chk("run_a",  run_a,  (m_a.rem != 0) ? 1 : 0);
    chk("tick_a", tick_a, m_a.tick);
    chk("exp_a",  exp_a,  m_a.exp);
    chk("rem_b",  rem_b,  m_b.rem);
    chk("tens_b", tens_b, m_b.rem / 10);
    chk("ones_b", ones_b, m_b.rem % 10);
    chk("run_b",  run_b,  (m_b.rem != 0) ? 1 : 0);
    chk("tick_b", tick_b, m_b.tick);
    chk("exp_b",  exp_b,  m_b.exp);
  end

  // Called at a falling edge; the load is sampled on the next rising edge and
  // the task returns at the falling edge right after that load edge.
  task automatic do_load(input int unsigned p);
    load   = 1'b1;
    preset = 6'(p);
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    preset = '0;
    pause  = 1'b0;
    cycles(2);
    chk("lit_reset_rem", rem_a, 0);
    chk("lit_reset_run", run_a, 0);
    rst_n = 1'b1;
    cycles(2);

    // Full countdown from 5.
    do_load(5);
    chk("lit_cd_load", rem_a, 5);
    cycles(3);
    chk("lit_cd_c3", rem_a, 5);
    cycles(1);
    chk("lit_cd_c4_rem", rem_a, 4);
    chk("lit_cd_c4_tick", tick_a, 1);
    cycles(15);
    chk("lit_cd_c19_exp", exp_a, 0);
    cycles(1);
    chk("lit_cd_c20_rem", rem_a, 0);
    chk("lit_cd_c20_exp", exp_a, 1);
    chk("lit_cd_c20_run", run_a, 0);
    cycles(1);
    chk("lit_cd_c21_exp", exp_a, 0);
    cycles(3);

    // Pause six cycles at remaining=3.
    do_load(5);
    cycles(8);
    chk("lit_pause_rem3", rem_a, 3);
    pause = 1'b1;
    cycles(6);
    chk("lit_pause_hold", rem_a, 3);
    pause = 1'b0;
    cycles(11);
    chk("lit_pause_c25_exp", exp_a, 0);
    cycles(1);
    chk("lit_pause_c26_exp", exp_a, 1);
    cycles(3);

    // Reload at remaining=12, prescaler=2.
    do_load(15);
    cycles(14);
    chk("lit_reload_pre", rem_a, 12);
    do_load(30);
    chk("lit_reload_rem", rem_a, 30);
    chk("lit_reload_tens", tens_a, 3);
    chk("lit_reload_ones", ones_a, 0);
    cycles(3);
    chk("lit_reload_c3", rem_a, 30);
    cycles(1);
    chk("lit_reload_c4", rem_a, 29);
    do_load(0);
    chk("lit_zero_exp", exp_a, 1);
    chk("lit_zero_run", run_a, 0);
    cycles(1);
    chk("lit_zero_exp_off", exp_a, 0);

    // Load lands on the edge that would take 1 -> 0.
    do_load(2);
    cycles(7);
    chk("lit_prio_rem1", rem_a, 1);
    do_load(22);
    chk("lit_prio_rem", rem_a, 22);
    chk("lit_prio_tens", tens_a, 2);
    chk("lit_prio_ones", ones_a, 2);
    chk("lit_prio_exp", exp_a, 0);
    chk("lit_prio_run", run_a, 1);

    // Load together with pause: new value held.
    pause = 1'b1;
    do_load(63);
    chk("lit_ldpause_tens", tens_a, 6);
    chk("lit_ldpause_ones", ones_a, 3);
    cycles(9);
    chk("lit_ldpause_hold", rem_a, 63);
    pause = 1'b0;

    // Asynchronous reset mid-count at remaining=9.
    do_load(15);
    cycles(24);
    chk("lit_ar_pre", rem_a, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_ar_rem", rem_a, 0);
    chk("lit_ar_run", run_a, 0);
    chk("lit_ar_tens", tens_a, 0);
    chk("lit_ar_ones", ones_a, 0);
    @(negedge clk);
    cycles(1);
    rst_n = 1'b1;
    cycles(8);
    chk("lit_ar_after", rem_a, 0);

    // CLK_DIV=1 instance.
    do_load(3);
    chk("lit_d1_load", rem_b, 3);
    cycles(1);
    chk("lit_d1_e1", rem_b, 2);
    cycles(1);
    chk("lit_d1_e2", rem_b, 1);
    cycles(1);
    chk("lit_d1_e3_rem", rem_b, 0);
    chk("lit_d1_e3_exp", exp_b, 1);
    cycles(20);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        preset = 6'($urandom_range(0, 3));
      else
        preset = 6'($urandom_range(0, 63));
      if (pause)
        pause = ($urandom_range(0, 3) != 0);
      else
        pause = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    load  = 1'b0;
    pause = 1'b0;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
